// File: rtl/atm_session_ctrl.sv
// Session sequencer for the CryptoATM keypad path: account lookup, PIN check,
// menu dispatch to the transaction datapath, PIN lockout and inactivity timeout.
module atm_session_ctrl #(
    parameter int unsigned MAX_PIN_TRIES  = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  status_code_in,
    input  logic [15:0] acct_in,
    input  logic [15:0] pswd_in,
    input  logic [1:0]  usr_input_in,
    input  logic [2:0]  currency_type_in,
    output logic [3:0]  input_style_out,
    output logic        db_req,
    output logic        db_op,
    output logic [15:0] db_acct,
    output logic [15:0] db_pswd,
    input  logic        db_ack,
    input  logic [3:0]  db_result,
    output logic        txn_start,
    output logic [1:0]  txn_op,
    output logic [2:0]  txn_currency,
    input  logic        txn_done,
    output logic        session_active,
    output logic        locked_out,
    output logic [3:0]  err_code
);

    localparam logic [3:0] STATUS_EXIT     = 4'b0111;
    localparam logic [3:0] STATUS_COMPLETE = 4'b1000;
    localparam logic [3:0] DB_ACC_FOUND    = 4'b0001;
    localparam logic [3:0] DB_PIN_CORRECT  = 4'b0011;
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0] TRIES_MAX       = 3'(MAX_PIN_TRIES);

    typedef enum logic [3:0] {
        IDLE, GET_ACCT, LOOKUP, GET_PIN, CHECK_PIN, MENU,
        GET_CUR, GET_AMT, EXEC, CONFIRM, LOCKED
    } state_t;

    state_t           state, nxt;
    logic [3:0]       status_q, err_d;
    logic [2:0]       pin_tries, tries_d;
    logic [CNT_W-1:0] tmo_cnt;
    logic             exit_ev, complete, waiting;

    // Edge-qualified decoder events; exit takes priority over complete
    assign exit_ev  = (status_code_in == STATUS_EXIT) && (status_q != STATUS_EXIT);
    assign complete = !exit_ev && (status_code_in == STATUS_COMPLETE)
                      && (status_q != STATUS_COMPLETE);
    assign waiting  = state inside {GET_ACCT, GET_PIN, MENU, GET_CUR, GET_AMT, CONFIRM};

    function automatic logic [3:0] style_of(input state_t s);
        case (s)
            GET_ACCT: style_of = 4'b0010;
            GET_PIN:  style_of = 4'b0011;
            MENU:     style_of = 4'b0100;
            GET_CUR:  style_of = 4'b0101;
            GET_AMT:  style_of = 4'b0110;
            CONFIRM:  style_of = 4'b0001;
            default:  style_of = 4'b0000;
        endcase
    endfunction

    // Next-state, fault code and retry count
    always_comb begin
        nxt     = state;
        err_d   = err_code;
        tries_d = pin_tries;
        case (state)
            IDLE: if (start) begin
                nxt     = GET_ACCT;
                err_d   = 4'd0;
                tries_d = 3'd0;
            end
            GET_ACCT: if (complete) nxt = LOOKUP;
            LOOKUP: if (db_ack) begin
                if (db_result == DB_ACC_FOUND) begin
                    nxt = GET_PIN;
                end else begin
                    nxt   = IDLE;
                    err_d = 4'd1;
                end
            end
            GET_PIN: if (complete) nxt = CHECK_PIN;
            CHECK_PIN: if (db_ack) begin
                if (db_result == DB_PIN_CORRECT) begin
                    nxt     = MENU;
                    tries_d = 3'd0;
                end else begin
                    tries_d = pin_tries + 3'd1;
                    if (tries_d == TRIES_MAX) begin
                        nxt   = LOCKED;
                        err_d = 4'd2;
                    end else begin
                        nxt = GET_PIN;
                    end
                end
            end
            MENU: if (complete) begin
                case (usr_input_in)
                    2'b01:   nxt = GET_CUR;
                    2'b10,
                    2'b11:   nxt = GET_AMT;
                    default: nxt = EXEC;
                endcase
            end
            GET_CUR: if (complete) nxt = GET_AMT;
            GET_AMT: if (complete) nxt = EXEC;
            EXEC:    if (txn_done) nxt = CONFIRM;
            CONFIRM: if (complete) nxt = MENU;
            default: ;
        endcase
        // User exit and inactivity timeout only apply while waiting on the keypad
        if (waiting) begin
            if (exit_ev) begin
                nxt   = IDLE;
                err_d = 4'd4;
            end else if (!complete && (tmo_cnt >= TMO_LAST)) begin
                nxt   = IDLE;
                err_d = 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            status_q        <= 4'd0;
            err_code        <= 4'd0;
            pin_tries       <= 3'd0;
            tmo_cnt         <= '0;
            input_style_out <= 4'd0;
            db_req          <= 1'b0;
            db_op           <= 1'b0;
            db_acct         <= 16'd0;
            db_pswd         <= 16'd0;
            txn_start       <= 1'b0;
            txn_op          <= 2'd0;
            txn_currency    <= 3'd0;
            session_active  <= 1'b0;
            locked_out      <= 1'b0;
        end else begin
            state           <= nxt;
            status_q        <= status_code_in;
            err_code        <= err_d;
            pin_tries       <= tries_d;
            input_style_out <= style_of(nxt);
            session_active  <= (nxt != IDLE);
            locked_out      <= (nxt == LOCKED);
            db_req          <= (nxt == LOOKUP) || (nxt == CHECK_PIN);
            txn_start       <= (nxt == EXEC) && (state != EXEC);
            if (nxt == LOOKUP)         db_op <= 1'b0;
            else if (nxt == CHECK_PIN) db_op <= 1'b1;
            if (complete) begin
                case (state)
                    GET_ACCT: db_acct      <= acct_in;
                    GET_PIN:  db_pswd      <= pswd_in;
                    MENU:     txn_op       <= usr_input_in;
                    GET_CUR:  txn_currency <= currency_type_in;
                    default: ;
                endcase
            end
            // Idle counter restarts on any progress; never runs past the trip value
            if ((nxt != state) || complete) begin
                tmo_cnt <= '0;
            end else if (waiting && (tmo_cnt < TMO_LAST)) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed bench for atm_session_ctrl: happy path, unknown account, lockout,
// convert flow, user exit, inactivity timeout and asynchronous reset.
module tb_atm_session_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  status_code_in;
    logic [15:0] acct_in;
    logic [15:0] pswd_in;
    logic [1:0]  usr_input_in;
    logic [2:0]  currency_type_in;
    logic [3:0]  input_style_out;
    logic        db_req;
    logic        db_op;
    logic [15:0] db_acct;
    logic [15:0] db_pswd;
    logic        db_ack;
    logic [3:0]  db_result;
    logic        txn_start;
    logic [1:0]  txn_op;
    logic [2:0]  txn_currency;
    logic        txn_done;
    logic        session_active;
    logic        locked_out;
    logic [3:0]  err_code;

    int total = 0;
    int bad   = 0;

    atm_session_ctrl #(.MAX_PIN_TRIES(3), .TIMEOUT_CYCLES(20), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .status_code_in(status_code_in),
        .acct_in(acct_in), .pswd_in(pswd_in), .usr_input_in(usr_input_in),
        .currency_type_in(currency_type_in), .input_style_out(input_style_out),
        .db_req(db_req), .db_op(db_op), .db_acct(db_acct), .db_pswd(db_pswd),
        .db_ack(db_ack), .db_result(db_result), .txn_start(txn_start),
        .txn_op(txn_op), .txn_currency(txn_currency), .txn_done(txn_done),
        .session_active(session_active), .locked_out(locked_out), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One idle cycle, then a single-cycle INPUT_COMPLETE edge
    task automatic compl();
        tick();
        status_code_in = 4'b1000;
        tick();
        status_code_in = 4'b0000;
    endtask

    task automatic ack(input logic [3:0] r);
        db_result = r;
        db_ack    = 1'b1;
        tick();
        db_ack    = 1'b0;
    endtask

    task automatic begin_session();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; status_code_in = 4'd0; acct_in = 16'd0;
        pswd_in = 16'd0; usr_input_in = 2'd0; currency_type_in = 3'd0;
        db_ack = 1'b0; db_result = 4'd0; txn_done = 1'b0;
        tick(); tick();
        chk("rst_style",  16'(input_style_out), 16'h0);
        chk("rst_req",    16'(db_req),          16'h0);
        chk("rst_active", 16'(session_active),  16'h0);
        chk("rst_err",    16'(err_code),        16'h0);
        chk("rst_acct",   db_acct,              16'h0);
        rst_n = 1'b1;
        tick();

        // Happy path: balance enquiry
        begin_session();
        chk("hp_style_acct", 16'(input_style_out), 16'h2);
        chk("hp_active",     16'(session_active),  16'h1);
        acct_in = 16'h1234;
        compl();
        chk("hp_lookup_req", 16'(db_req),          16'h1);
        chk("hp_lookup_op",  16'(db_op),           16'h0);
        chk("hp_db_acct",    db_acct,              16'h1234);
        chk("hp_style_lk",   16'(input_style_out), 16'h0);
        ack(4'b0001);
        chk("hp_req_drop",   16'(db_req),          16'h0);
        chk("hp_style_pin",  16'(input_style_out), 16'h3);
        pswd_in = 16'h4321;
        compl();
        chk("hp_chk_req",    16'(db_req),          16'h1);
        chk("hp_chk_op",     16'(db_op),           16'h1);
        chk("hp_db_pswd",    db_pswd,              16'h4321);
        ack(4'b0011);
        chk("hp_style_menu", 16'(input_style_out), 16'h4);
        usr_input_in = 2'b00;
        compl();
        chk("hp_txn_start",  16'(txn_start),       16'h1);
        chk("hp_txn_op",     16'(txn_op),          16'h0);
        tick();
        chk("hp_txn_pulse",  16'(txn_start),       16'h0);
        txn_done = 1'b1;
        tick();
        txn_done = 1'b0;
        chk("hp_style_conf", 16'(input_style_out), 16'h1);
        compl();
        chk("hp_back_menu",  16'(input_style_out), 16'h4);

        // Inactivity in MENU: trips on the 20th cycle after entry
        repeat (19) tick();
        chk("tmo_not_yet",   16'(input_style_out), 16'h4);
        tick();
        chk("tmo_style",     16'(input_style_out), 16'h0);
        chk("tmo_err",       16'(err_code),        16'h3);
        chk("tmo_active",    16'(session_active),  16'h0);

        // Unknown account
        begin_session();
        chk("ua_err_clear",  16'(err_code),        16'h0);
        acct_in = 16'h0BAD;
        compl();
        ack(4'b0010);
        chk("ua_err",        16'(err_code),        16'h1);
        chk("ua_active",     16'(session_active),  16'h0);
        chk("ua_req",        16'(db_req),          16'h0);

        // Convert flow with a held complete level
        begin_session();
        acct_in = 16'h1111;
        compl();
        ack(4'b0001);
        pswd_in = 16'h2222;
        compl();
        ack(4'b0011);
        usr_input_in = 2'b01;
        compl();
        chk("cv_style_cur",  16'(input_style_out), 16'h5);
        chk("cv_txn_op",     16'(txn_op),          16'h1);
        currency_type_in = 3'b010;
        tick();
        status_code_in = 4'b1000;
        tick();
        chk("cv_style_amt",  16'(input_style_out), 16'h6);
        chk("cv_currency",   16'(txn_currency),    16'h2);
        repeat (4) tick();
        chk("cv_level_hold", 16'(input_style_out), 16'h6);
        status_code_in = 4'b0000;
        compl();
        chk("cv_txn_start",  16'(txn_start),       16'h1);
        chk("cv_txn_op2",    16'(txn_op),          16'h1);
        chk("cv_txn_cur2",   16'(txn_currency),    16'h2);
        txn_done = 1'b1;
        tick();
        txn_done = 1'b0;
        chk("cv_same_done",  16'(input_style_out), 16'h1);
        compl();
        usr_input_in = 2'b10;
        compl();
        chk("ex_style_amt",  16'(input_style_out), 16'h6);
        status_code_in = 4'b0111;
        tick();
        status_code_in = 4'b0000;
        chk("ex_err",        16'(err_code),        16'h4);
        chk("ex_active",     16'(session_active),  16'h0);

        // Exit ignored during LOOKUP, then async reset during CHECK_PIN
        begin_session();
        acct_in = 16'h3333;
        compl();
        status_code_in = 4'b0111;
        tick();
        status_code_in = 4'b0000;
        chk("lx_req_held",   16'(db_req),          16'h1);
        chk("lx_active",     16'(session_active),  16'h1);
        ack(4'b0001);
        chk("lx_style_pin",  16'(input_style_out), 16'h3);
        compl();
        chk("ar_req_before", 16'(db_req),          16'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_req_async",  16'(db_req),          16'h0);
        chk("ar_active",     16'(session_active),  16'h0);
        rst_n = 1'b1;
        tick();
        chk("ar_idle_style", 16'(input_style_out), 16'h0);
        chk("ar_idle_req",   16'(db_req),          16'h0);

        // Lockout after three wrong PINs
        begin_session();
        acct_in = 16'h5555;
        compl();
        ack(4'b0001);
        for (int i = 0; i < 3; i++) begin
            compl();
            ack(4'b0100);
            if (i < 2) chk("lk_retry", 16'(input_style_out), 16'h3);
        end
        chk("lk_locked",     16'(locked_out),      16'h1);
        chk("lk_err",        16'(err_code),        16'h2);
        chk("lk_style",      16'(input_style_out), 16'h0);
        begin_session();
        tick();
        chk("lk_start_ign",  16'(locked_out),      16'h1);
        chk("lk_still_act",  16'(session_active),  16'h1);
        rst_n = 1'b0;
        #2;
        chk("lk_rst_lock",   16'(locked_out),      16'h0);
        chk("lk_rst_err",    16'(err_code),        16'h0);
        chk("lk_rst_acct",   db_acct,              16'h0);
        chk("lk_rst_pswd",   db_pswd,              16'h0);
        chk("lk_rst_cur",    16'(txn_currency),    16'h0);
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
